// File: rtl/fetch_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of the five-stage pipeline. Holds the
//            program counter, presents it as the instruction-memory address,
//            and registers the fetched word into the IF/ID pipeline register.
//            Honours reset, branch redirect, stall and flush commands, in that
//            priority order.
// Revision : 1.0 - initial release
//
// Parameters
//   PC_W      program counter / address width (byte addressed)
//   INSTR_W   instruction width
//   RESET_PC  PC loaded on reset (word aligned)
//
// Ports
//   clk            in   pipeline clock, rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hold PC and IF/ID
//   flush          in   replace next IF/ID contents with a bubble
//   branch_taken   in   redirect fetch to branch_target
//   branch_target  in   redirect address (low two bits ignored)
//   imem_addr      out  instruction-memory address (= PC)
//   imem_data      in   instruction word, combinational read of imem_addr
//   ifid_pc_plus4  out  registered PC+4 of the fetched instruction
//   ifid_instr     out  registered instruction, 0 for a bubble
//   ifid_valid     out  IF/ID holds a real instruction
//   halted         out  fetch frozen by a halt word
//
// Configuration
//   FETCH_HALT_EN  when defined, an all-ones instruction word freezes fetch
//                  until reset or a taken branch. When undefined, halted is
//                  tied to 0 and the all-ones word is fetched normally.
//------------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned            PC_W     = 32,
  parameter int unsigned            INSTR_W  = 32,
  parameter logic [PC_W-1:0]        RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_target,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [PC_W-1:0]     ifid_pc_plus4,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic                ifid_valid,
  output logic                halted
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target_aligned;
  logic            halt_state;
  logic            halt_hit;

  // Wraps modulo 2^PC_W with no carry out.
  assign pc_plus4       = pc + PC_STEP;
  assign target_aligned = {branch_target[PC_W-1:2], 2'b00};
  assign imem_addr      = pc;

`ifdef FETCH_HALT_EN
  // Halt word is recognised only on a normal fetch cycle; the priority chain
  // below already excludes reset, branch, stall and an existing halt, so only
  // flush has to be masked here.
  assign halt_hit = (imem_data == {INSTR_W{1'b1}}) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      halt_state <= 1'b0;
    end else if (branch_taken) begin
      halt_state <= 1'b0;
    end else if (!stall && !halt_state && halt_hit) begin
      halt_state <= 1'b1;
    end
  end
`else
  assign halt_hit   = 1'b0;
  assign halt_state = 1'b0;
`endif

  assign halted = halt_state;

  // PC and IF/ID register. A bubble clears instr/valid but leaves
  // ifid_pc_plus4 untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_pc_plus4 <= '0;
      ifid_instr    <= '0;
      ifid_valid    <= 1'b0;
    end else if (branch_taken) begin
      pc         <= target_aligned;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      if (flush) begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end
    end else if (halt_state) begin
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      pc         <= pc_plus4;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (halt_hit) begin
      // PC parks on the halt word; the word itself never reaches decode.
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      ifid_pc_plus4 <= pc_plus4;
      ifid_instr    <= imem_data;
      ifid_valid    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage. A small word array
//            models instruction memory; expected values are hand computed.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] mem [64];

  int n_checks;
  int n_pass;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed memory: address bits [7:2] select the word, so 0xFFFFFFFC
  // maps to word 63.
  assign imem_data = mem[imem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] addr,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
    check({tag, ".addr"},  imem_addr,     addr);
    check({tag, ".instr"}, ifid_instr,    instr);
    check({tag, ".pc4"},   ifid_pc_plus4, pc4);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h0000_0011;
    mem[1]  = 32'h0000_0022;
    mem[2]  = 32'h0000_0033;
    mem[3]  = 32'h0000_0044;
    mem[16] = 32'h4040_4040;

    // Reset state
    do_reset();
    check_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst.halted", {31'd0, halted}, 32'h0);

    // Three free-running fetches
    step(); check_ifid("f1", 32'd4,  32'h11, 32'd4,  1'b1);
    step(); check_ifid("f2", 32'd8,  32'h22, 32'd8,  1'b1);
    step(); check_ifid("f3", 32'd12, 32'h33, 32'd12, 1'b1);

    // Mid-run reset discards IF/ID, then stall two cycles at pc=8
    do_reset();
    check_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    step(); step();
    check_ifid("pre_stall", 32'd8, 32'h22, 32'd8, 1'b1);
    stall = 1'b1;
    step(); check_ifid("stall1", 32'd8, 32'h22, 32'd8, 1'b1);
    step(); check_ifid("stall2", 32'd8, 32'h22, 32'd8, 1'b1);
    stall = 1'b0;
    step(); check_ifid("resume", 32'd12, 32'h33, 32'd12, 1'b1);

    // Stall with flush: bubble, pc holds, pc_plus4 untouched
    stall = 1'b1; flush = 1'b1;
    step(); check_ifid("stall_flush", 32'd12, 32'h0, 32'd12, 1'b0);
    flush = 1'b0;

    // Branch overrides stall; target low bits masked
    branch_taken = 1'b1; branch_target = 32'h42;
    step(); check_ifid("br", 32'h40, 32'h0, 32'd12, 1'b0);
    branch_taken = 1'b0; stall = 1'b0;
    step(); check_ifid("br_tgt", 32'h44, 32'h4040_4040, 32'h44, 1'b1);

    // Flush alone at pc=4: bubble, pc still advances
    do_reset();
    step(); check_ifid("fl_pre", 32'd4, 32'h11, 32'd4, 1'b1);
    flush = 1'b1;
    step(); check_ifid("flush", 32'd8, 32'h0, 32'd4, 1'b0);
    flush = 1'b0;
    step(); check_ifid("fl_post", 32'd12, 32'h33, 32'd12, 1'b1);

    // PC wrap at 0xFFFFFFFC
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step(); check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step(); check_ifid("wrap", 32'h0, 32'h1000_003F, 32'h0, 1'b1);
    step(); check_ifid("wrap2", 32'd4, 32'h11, 32'd4, 1'b1);

    // All-ones word at address 8
    mem[2] = 32'hFFFF_FFFF;
    do_reset();
    step(); step();
    check_ifid("h_pre", 32'd8, 32'h22, 32'd8, 1'b1);
    step();
`ifdef FETCH_HALT_EN
    check_ifid("halt1", 32'd8, 32'h0, 32'd8, 1'b0);
    check("halt1.halted", {31'd0, halted}, 32'h1);
    step();
    check_ifid("halt2", 32'd8, 32'h0, 32'd8, 1'b0);
    check("halt2.halted", {31'd0, halted}, 32'h1);
    branch_taken = 1'b1; branch_target = 32'h0;
    step();
    branch_taken = 1'b0;
    check_ifid("unhalt", 32'h0, 32'h0, 32'd8, 1'b0);
    check("unhalt.halted", {31'd0, halted}, 32'h0);
    step(); check_ifid("restart", 32'd4, 32'h11, 32'd4, 1'b1);
`else
    check_ifid("nohalt", 32'd12, 32'hFFFF_FFFF, 32'd12, 1'b1);
    check("nohalt.halted", {31'd0, halted}, 32'h0);
    step(); check_ifid("nohalt2", 32'd16, 32'h44, 32'd16, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
